// File: rtl/servo_slew_ramp_pkg.sv
// Shared servo definitions: default position width, centre position and ramp FSM states.
// Used by servo_slew_ramp, its step timer and servo_controller.
package servo_pkg;

  localparam int POS_W_DEF     = 8;
  localparam int RESET_POS_DEF = 128;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MOVE = 1'b1
  } state_t;

endpackage

// File: rtl/servo_slew_ramp_step_timer.sv
// Step timer for servo_slew_ramp: counts enabled cycles and emits a one-cycle tick
// when the count reaches div-1 (div of 0 behaves as 1), then wraps to zero.
module step_timer
  import servo_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;
  logic [DIV_W-1:0] last_s;

  always_comb begin
    last_s = (div == CNT_ZERO) ? CNT_ZERO : (div - CNT_ONE);
    tick   = en && (count_q == last_s);
    if (clr) begin
      count_d = CNT_ZERO;
    end else if (tick) begin
      count_d = CNT_ZERO;
    end else if (en) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= CNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/servo_slew_ramp.sv
// Slew-rate-limited servo position generator: ramps position 1 LSB per rate period toward
// an accepted target. Optional target clamping to [MIN_POS, MAX_POS] via SERVO_RAMP_LIMIT_EN.
module servo_slew_ramp
  import servo_pkg::*;
#(
  parameter int POS_W     = POS_W_DEF,
  parameter int DIV_W     = 16,
  parameter int RESET_POS = RESET_POS_DEF,
  parameter int MIN_POS   = 16,
  parameter int MAX_POS   = 240
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             target_valid,
  output logic             target_ready,
  input  logic [POS_W-1:0] target,
  input  logic [DIV_W-1:0] rate_div,
  input  logic             stop,
  output logic [POS_W-1:0] position,
  output logic             moving,
  output logic             done
);

`ifdef SERVO_RAMP_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam logic [POS_W-1:0] POS_RST = POS_W'(RESET_POS);
  localparam logic [POS_W-1:0] POS_MIN = POS_W'(MIN_POS);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(MAX_POS);
  localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] t);
    logic [POS_W-1:0] r;
    if (LIMIT_EN && (t < POS_MIN)) begin
      r = POS_MIN;
    end else if (LIMIT_EN && (t > POS_MAX)) begin
      r = POS_MAX;
    end else begin
      r = t;
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [POS_W-1:0] position_q, position_d;
  logic [POS_W-1:0] target_q, target_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             up_q, up_d;
  logic             done_q, done_d;

  logic             accept_s;
  logic             tmr_clr_s;
  logic             tmr_en_s;
  logic             tick_s;
  logic [POS_W-1:0] clamped_s;
  logic [POS_W-1:0] step_s;

  step_timer #(.DIV_W(DIV_W)) u_step_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr_s),
    .en   (tmr_en_s),
    .div  (div_q),
    .tick (tick_s)
  );

  // stop overrides everything, including a same-cycle target offer
  assign target_ready = (state_q == ST_IDLE) && !stop;
  assign moving       = (state_q == ST_MOVE);
  assign position     = position_q;
  assign done         = done_q;

  always_comb begin
    state_d    = state_q;
    position_d = position_q;
    target_d   = target_q;
    div_d      = div_q;
    up_d       = up_q;
    done_d     = 1'b0;
    tmr_clr_s  = 1'b0;
    tmr_en_s   = 1'b0;
    accept_s   = target_valid && target_ready;
    clamped_s  = clamp_pos(target);
    step_s     = up_q ? (position_q + POS_ONE) : (position_q - POS_ONE);

    if (stop) begin
      state_d   = ST_IDLE;
      tmr_clr_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            target_d  = clamped_s;
            div_d     = rate_div;
            up_d      = (clamped_s > position_q);
            tmr_clr_s = 1'b1;
            if (clamped_s != position_q) begin
              state_d = ST_MOVE;
            end else begin
              done_d  = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MOVE: begin
          tmr_en_s = 1'b1;
          // the step that lands on the target ends the move and arms done
          if (tick_s) begin
            position_d = step_s;
            if (step_s == target_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_MOVE;
            end
          end else begin
            position_d = position_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      position_q <= POS_RST;
      target_q   <= POS_RST;
      div_q      <= {DIV_W{1'b0}};
      up_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      position_q <= position_d;
      target_q   <= target_d;
      div_q      <= div_d;
      up_q       <= up_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_servo_slew_ramp.sv
// Scoreboard bench for servo_slew_ramp: expected per-cycle outputs are queued when a
// move is launched and compared on each falling edge. Honours SERVO_RAMP_LIMIT_EN.
module tb_servo_slew_ramp;

  typedef struct packed {
    logic [7:0] pos;
    logic       moving;
    logic       done;
    logic       ready;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        target_valid = 1'b0;
  logic        target_ready;
  logic [7:0]  target = 8'd0;
  logic [15:0] rate_div = 16'd0;
  logic        stop = 1'b0;
  logic [7:0]  position;
  logic        moving;
  logic        done;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   model_pos = 128;

  servo_slew_ramp dut (
    .clk          (clk),
    .rst          (rst),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .target       (target),
    .rate_div     (rate_div),
    .stop         (stop),
    .position     (position),
    .moving       (moving),
    .done         (done)
  );

  always #10 clk = ~clk;

  function automatic int exp_clamp(input int t);
`ifdef SERVO_RAMP_LIMIT_EN
    if (t < 16) return 16;
    if (t > 240) return 240;
`endif
    return t;
  endfunction

  function automatic exp_t mk(input int p, input bit mv, input bit dn, input bit rd);
    exp_t e;
    e.pos = p[7:0]; e.moving = mv; e.done = dn; e.ready = rd;
    return e;
  endfunction

  task automatic offer(input int t, input int d);
    @(posedge clk); #1;
    target_valid = 1'b1; target = t[7:0]; rate_div = d[15:0];
    @(posedge clk); #1;
    target_valid = 1'b0; target = 8'($urandom); rate_div = 16'($urandom);
  endtask

  // generic move: model the whole ramp, launch it, then compare every cycle
  task automatic run_move(input string name, input int tgt, input int div);
    int t, d, n, p0, k, p;
    bit up;
    exp_t e, a;
    p0 = model_pos; t = exp_clamp(tgt); d = (div == 0) ? 1 : div;
    up = (t > p0); n = up ? (t - p0) : (p0 - t);
    if (n == 0) begin
      sb.push_back(mk(p0, 1'b0, 1'b1, 1'b1));
      sb.push_back(mk(p0, 1'b0, 1'b0, 1'b1));
    end else begin
      for (k = 0; k <= d * n + 1; k++) begin
        p = (k / d > n) ? n : k / d;
        sb.push_back(mk(up ? p0 + p : p0 - p, k < d * n, k == d * n, k >= d * n));
      end
    end
    offer(tgt, div);
    k = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      a = {position, moving, done, target_ready};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s k=%0d pos=%0d/%0d moving=%0b/%0b done=%0b/%0b ready=%0b/%0b",
                 name, k, a.pos, e.pos, a.moving, e.moving, a.done, e.done, a.ready, e.ready);
      end
      k++;
    end
    model_pos = t;
  endtask

  task automatic test_reset();
    exp_t e, a;
    for (int k = 0; k < 5; k++) sb.push_back(mk(128 - k, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(128, 1'b0, 1'b0, 1'b1));
    offer(100, 1);
    for (int k = 0; k < 6; k++) begin
      if (k < 5) @(negedge clk);
      else begin
        #2 rst = 1'b1;
        #1;
      end
      e = sb.pop_front();
      a = {position, moving, done, target_ready};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL reset k=%0d pos=%0d/%0d moving=%0b/%0b done=%0b/%0b ready=%0b/%0b",
                 k, a.pos, e.pos, a.moving, e.moving, a.done, e.done, a.ready, e.ready);
      end
    end
    @(negedge clk); rst = 1'b0;
    model_pos = 128;
  endtask

  task automatic test_stop();
    exp_t e, a;
    for (int k = 0; k <= 120; k++) sb.push_back(mk(128 + k / 10, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 2; k++) sb.push_back(mk(140, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) sb.push_back(mk(140, 1'b0, 1'b0, 1'b1));
    offer(200, 10);
    for (int k = 0; k < 127; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      a = {position, moving, done, target_ready};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL stop k=%0d pos=%0d/%0d moving=%0b/%0b done=%0b/%0b ready=%0b/%0b",
                 k, a.pos, e.pos, a.moving, e.moving, a.done, e.done, a.ready, e.ready);
      end
      if (k == 120) begin
        stop = 1'b1; target_valid = 1'b1; target = 8'd50; rate_div = 16'd1;
      end
      if (k == 122) begin
        stop = 1'b0; target_valid = 1'b0;
      end
    end
    model_pos = 140;
  endtask

  task automatic test_limit();
    exp_t e, a;
    int p0;
    run_move("limit", 250, 1);
    p0 = model_pos;
    for (int k = 0; k < 6; k++) sb.push_back(mk(p0 - k / 2, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(128, 1'b0, 1'b0, 1'b1));
    sb.push_back(mk(128, 1'b0, 1'b0, 1'b1));
    sb.push_back(mk(128, 1'b0, 1'b0, 1'b1));
    offer(10, 2);
    for (int k = 0; k < 9; k++) begin
      if (k == 6) begin
        #2 rst = 1'b1;
        #1;
      end else begin
        @(negedge clk);
        if (k == 7) rst = 1'b0;
      end
      e = sb.pop_front();
      a = {position, moving, done, target_ready};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL limit_rst k=%0d pos=%0d/%0d moving=%0b/%0b done=%0b/%0b ready=%0b/%0b",
                 k, a.pos, e.pos, a.moving, e.moving, a.done, e.done, a.ready, e.ready);
      end
    end
    model_pos = 128;
  endtask

  initial begin
    #25 rst = 1'b0;
    test_reset();
    run_move("ramp_up", 131, 4);
    run_move("ramp_down", 128, 0);
    run_move("equal", 128, 3);
    test_stop();
    test_limit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
